// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width helper for the multi-ported register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned NRD_DEF  = 2;
    localparam int unsigned NWR_DEF  = 2;

    // Address width for a power-of-two register count.
    function automatic int unsigned addr_width(input int unsigned nreg);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < nreg) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: set on issue, clear on writeback, set wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = NRD_DEF,
    parameter int unsigned NWR  = NWR_DEF,
    parameter int unsigned AW   = addr_width(NREG_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] busy_cleared;
    logic [NREG-1:0] busy_next;

    // Any enabled write port retires the outstanding producer of its address.
    always_comb begin
        clr_mask = '0;
        for (int j = 0; j < int'(NWR); j++) begin
            if (we[j]) begin
                clr_mask[waddr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        set_mask = '0;
        if (iss_valid && (iss_rd != '0)) begin
            set_mask[iss_rd] = 1'b1;
        end
    end

    assign busy_cleared = busy_q & ~clr_mask;
    // Set applied after clear so a new producer stays outstanding; x0 never busy.
    assign busy_next    = (busy_cleared | set_mask) & ~NREG'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // Read-side view reflects same-cycle writebacks but not same-cycle issues.
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            if (raddr[i*AW +: AW] != '0) begin
                rbusy[i] = busy_cleared[raddr[i*AW +: AW]];
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with hardwired-zero x0 and an issue/writeback scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN = XLEN_DEF,
    parameter  int unsigned NREG = NREG_DEF,
    parameter  int unsigned NRD  = NRD_DEF,
    parameter  int unsigned NWR  = NWR_DEF,
    localparam int unsigned AW   = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs    [NREG];
    logic [AW-1:0]   raddr_a [NRD];
    logic [XLEN-1:0] rdata_a [NRD];
    logic [AW-1:0]   waddr_a [NWR];
    logic [XLEN-1:0] wdata_a [NWR];

    for (genvar g = 0; g < int'(NRD); g++) begin : g_rd_unpack
        assign raddr_a[g]                 = raddr[g*AW +: AW];
        assign rdata[g*XLEN +: XLEN]      = rdata_a[g];
    end

    for (genvar g = 0; g < int'(NWR); g++) begin : g_wr_unpack
        assign waddr_a[g] = waddr[g*AW +: AW];
        assign wdata_a[g] = wdata[g*XLEN +: XLEN];
    end

    // Ascending port loop: the last assignment, i.e. highest port, wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NREG); k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (we[j] && (waddr_a[j] != '0)) begin
                    regs[waddr_a[j]] <= wdata_a[j];
                end
            end
        end
    end

    // Combinational read; x0 is forced to zero rather than stored.
    always_comb begin
        for (int i = 0; i < int'(NRD); i++) begin
            rdata_a[i] = '0;
            if (raddr_a[i] != '0) begin
                rdata_a[i] = regs[raddr_a[i]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int j = 0; j < int'(NWR); j++) begin
                    if (we[j] && (waddr_a[j] == raddr_a[i])) begin
                        rdata_a[i] = wdata_a[j];
                    end
                end
`endif
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .waddr     (waddr),
        .raddr     (raddr),
        .rbusy     (rbusy),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then randomized traffic vs a reference model.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy_vec;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] rdata;
        logic [1:0]  rbusy;
        logic [31:0] busy_vec;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          model_known = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;

    // Architectural read value seen during a cycle with the given write traffic.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [1:0] w,
                                             input logic [4:0] wa0, input logic [4:0] wa1,
                                             input logic [31:0] wd0, input logic [31:0] wd1);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_reg[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (w[1] && wa1 == a) v = wd1;
        else if (w[0] && wa0 == a) v = wd0;
`endif
        return v;
    endfunction

    function automatic logic ref_busy(input logic [4:0] a, input logic [1:0] w,
                                      input logic [4:0] wa0, input logic [4:0] wa1);
        if (a == 5'd0) return 1'b0;
        if ((w[0] && wa0 == a) || (w[1] && wa1 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic step(input logic r, input logic [1:0] w,
                        input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic iv, input logic [4:0] ird);
        exp_t e;
        rst = r; we = w; waddr = {wa1, wa0}; wdata = {wd1, wd0};
        raddr = {ra1, ra0}; iss_valid = iv; iss_rd = ird;
        if (model_known) begin
            e.cyc   = 32'(cyc);
            e.rdata = {ref_read(ra1, w, wa0, wa1, wd0, wd1), ref_read(ra0, w, wa0, wa1, wd0, wd1)};
            e.rbusy = {ref_busy(ra1, w, wa0, wa1), ref_busy(ra0, w, wa0, wa1)};
            for (int k = 0; k < 32; k++) e.busy_vec[k] = m_busy[k];
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) begin
                m_reg[k] = 32'd0;
                m_busy[k] = 1'b0;
            end
            model_known = 1'b1;
        end else begin
            if (w[0] && wa0 != 5'd0) m_reg[wa0] = wd0;
            if (w[1] && wa1 != 5'd0) m_reg[wa1] = wd1;
            if (w[0]) m_busy[wa0] = 1'b0;
            if (w[1]) m_busy[wa1] = 1'b0;
            if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
            m_busy[0] = 1'b0;
        end
        #1;
        cyc++;
    endtask

    task automatic idle_read(input logic [4:0] ra0, input logic [4:0] ra1);
        step(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, ra0, ra1, 1'b0, 5'd0);
    endtask

    task automatic check(input string name, input logic [31:0] c,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=0x%h exp=0x%h", name, c, got, exp);
    endtask

    // Monitor: outputs are combinational and settle well before the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdata0", e.cyc, rdata[31:0], e.rdata[31:0]);
                check("rdata1", e.cyc, rdata[63:32], e.rdata[63:32]);
                check("rbusy0", e.cyc, 32'(rbusy[0]), 32'(e.rbusy[0]));
                check("rbusy1", e.cyc, 32'(rbusy[1]), 32'(e.rbusy[1]));
                check("busy_vec", e.cyc, busy_vec, e.busy_vec);
            end
        end
    end

    initial begin
        logic [4:0] a [6];
        // Reset for two cycles, then sweep r1..r31.
        step(1'b1, 2'b00, 5'd3, 5'd4, 32'd1, 32'd2, 5'd1, 5'd2, 1'b1, 5'd5);
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0);
        for (int r = 1; r < 32; r += 2) idle_read(5'(r), 5'(r + 1));

        // Both write ports hit r5; port 1 must win.
        step(1'b0, 2'b11, 5'd5, 5'd5, 32'hAAAA, 32'hBBBB, 5'd5, 5'd0, 1'b0, 5'd0);
        idle_read(5'd5, 5'd5);

        // Same-cycle write and read of r7.
        step(1'b0, 2'b01, 5'd7, 5'd0, 32'h1234, 32'd0, 5'd7, 5'd5, 1'b0, 5'd0);
        idle_read(5'd7, 5'd0);

        // Issue r3, wait, write back in cycle 4, observe cycle 5.
        step(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0, 1'b1, 5'd3);
        for (int i = 0; i < 3; i++) idle_read(5'd3, 5'd0);
        step(1'b0, 2'b10, 5'd0, 5'd3, 32'd0, 32'h3333, 5'd3, 5'd3, 1'b0, 5'd0);
        idle_read(5'd3, 5'd0);

        // Issue and writeback of r9 in the same cycle.
        step(1'b0, 2'b01, 5'd9, 5'd0, 32'h9999, 32'd0, 5'd9, 5'd0, 1'b1, 5'd9);
        idle_read(5'd9, 5'd9);

        // x0 writes/issues ignored; reset drops an outstanding busy bit.
        step(1'b0, 2'b11, 5'd0, 5'd0, 32'hFFFF, 32'hFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
        idle_read(5'd0, 5'd2);
        step(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd2, 5'd0, 1'b1, 5'd2);
        step(1'b1, 2'b01, 5'd2, 5'd0, 32'h2222, 32'd0, 5'd2, 5'd9, 1'b1, 5'd4);
        idle_read(5'd2, 5'd9);

        // Randomized traffic, biased toward low addresses for collisions.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 6; k++)
                a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)), a[0], a[1],
                 $urandom, $urandom, a[2], a[3], 1'($urandom_range(0, 1)), a[4]);
        end
        idle_read(5'd1, 5'd2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32: number of registers, a power of two and at least 2.
REQ-003 The block SHALL have parameter NRD, default 2: number of read ports.
REQ-004 The block SHALL have parameter NWR, default 2: number of write ports.
REQ-005 The block SHALL use AW = log2(NREG) as the address width.
REQ-006 Port clk SHALL be an input of width 1: the single clock, with all state updated on its rising edge.
REQ-007 Port rst SHALL be an input of width 1: reset, synchronous and active-high.
REQ-008 Port raddr SHALL be an input of width NRD x AW: read addresses.
REQ-009 Port rdata SHALL be an output of width NRD x XLEN: read data.
REQ-010 Port rbusy SHALL be an output of width NRD: scoreboard busy bit for each read address.
REQ-011 Port we SHALL be an input of width NWR: write enables.
REQ-012 Port waddr SHALL be an input of width NWR x AW: write addresses.
REQ-013 Port wdata SHALL be an input of width NWR x XLEN: write data.
REQ-014 Port iss_valid SHALL be an input of width 1: an instruction issues this cycle.
REQ-015 Port iss_rd SHALL be an input of width AW: destination register of the issuing instruction.
REQ-016 Port busy_vec SHALL be an output of width NREG: full scoreboard state.

Function
REQ-017 Register 0 SHALL read as zero, ignore writes, and never be marked busy.
REQ-018 Reads SHALL be combinational: rdata[i] = reg[raddr[i]], with zero latency.
REQ-019 A write SHALL commit at the rising clk edge when we[j]=1 and waddr[j]!=0.
REQ-020 When several write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-021 A scoreboard bit SHALL be set at the edge when iss_valid=1 and iss_rd!=0.
REQ-022 A scoreboard bit SHALL be cleared at the edge when any we[j]=1 targets that address.
REQ-023 When a set and a clear hit the same register in one cycle, the set SHALL win (the new producer is outstanding).
REQ-024 rbusy[i] SHALL equal busy_vec[raddr[i]] after same-cycle clears are applied, i.e. a same-cycle writeback SHALL show not busy.
REQ-025 rbusy[i] SHALL ignore a same-cycle issue; the new busy state SHALL be visible from the next cycle only.
REQ-026 rbusy[i] and rdata[i] SHALL be 0 when raddr[i]=0.

Reset
REQ-027 When rst=1 at a rising edge, all registers SHALL become 0 and all busy bits SHALL become 0.
REQ-028 Reset SHALL take priority over any same-cycle write or issue.
REQ-029 In the cycle after reset, all rdata, rbusy and busy_vec outputs SHALL be 0.
REQ-030 A reset asserted while a write is outstanding SHALL discard it, and no busy bit SHALL survive.

Configuration
REQ-031 When REGFILE_MP_BYPASS_EN is defined, rdata[i] SHALL return the winning same-cycle wdata when any we[j] targets raddr[i]!=0 (write-to-read forwarding).
REQ-032 When REGFILE_MP_BYPASS_EN is undefined, rdata[i] SHALL return the pre-edge stored value, and the written value SHALL be visible from the next cycle.
REQ-033 The rbusy behaviour in REQ-024 SHALL be identical in both configurations.

Structure
REQ-034 Package regfile_pkg SHALL hold the default XLEN/NREG/NRD/NWR constants and the function computing AW.
REQ-035 The scoreboard (busy_vec state with its set/clear priority) SHALL be a separate sub-module, regfile_scoreboard; storage and read muxing SHALL stay in regfile_mp.

Verification
REQ-036 Reset: hold rst=1 for 2 cycles, then read r1..r31 -> every rdata is 0 and busy_vec is 0.
REQ-037 Dual write: we=2'b11, waddr = {5, 5}, wdata = {0xBBBB, 0xAAAA}; read r5 next cycle -> 0xBBBB (port 1 wins).
REQ-038 Forwarding: write r7=0x1234 while raddr[0]=7 in the same cycle -> with BYPASS_EN rdata[0]=0x1234; without it, rdata[0] is the old value, and 0x1234 appears the next cycle.
REQ-039 Scoreboard: issue rd=3 in cycle 0 -> busy_vec[3]=1 in cycle 1; writeback r3 in cycle 4 -> rbusy for r3 is 0 in cycle 4, and busy_vec[3]=0 in cycle 5.
REQ-040 Set/clear collision: issue rd=9 and write r9 in the same cycle -> busy_vec[9]=1 next cycle, and r9 holds the written data.
REQ-041 x0 and mid-operation reset: write r0=0xFFFF and issue rd=0 -> r0 reads 0 and is never busy; set busy on r2, then assert rst -> busy_vec=0 in the following cycle.
